// File: rtl/mem_arbiter.sv
// Shares one RAM between the CPU memory path and an external requester.
// Ownership changes only at CPU instruction boundaries. Each grant allows at most BURST_MAX accesses.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int BURST_MAX = 8
) (
  input  logic              i_nclk,
  input  logic              i_reset,
  input  logic              i_instrFinishedN,
  input  logic [ADDR_W-1:0] i_cpuAddr,
  input  logic [7:0]        i_cpuData,
  input  logic              i_cpuRamNWE,
  input  logic              i_cpuRamNOE,
  output logic [7:0]        o_cpuData,
  output logic              o_halt,
  input  logic              i_extReq,
  input  logic              i_extWe,
  input  logic              i_extStb,
  input  logic [ADDR_W-1:0] i_extAddr,
  input  logic [7:0]        i_extData,
  output logic              o_extGnt,
  output logic              o_extAck,
  output logic [7:0]        o_extData,
  output logic [ADDR_W-1:0] o_ramAddr,
  output logic [7:0]        o_ramData,
  input  logic [7:0]        i_ramData,
  output logic              o_ramNWE,
  output logic              o_ramNOE
);

  typedef enum logic [2:0] {
    S_CPU, S_WAIT, S_IDLE, S_SETUP, S_STROBE, S_COOL
  } state_t;

  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              own_q, own_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_CPU: begin
        cnt_d = 8'd0;
        if (i_extReq) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!i_instrFinishedN) state_d = S_IDLE;
        else if (!i_extReq)    state_d = S_CPU;
      end
      S_IDLE: begin
        // A strobe wins over a same-cycle request drop so the access is not lost.
        if (i_extStb) begin
          addr_d  = i_extAddr;
          wdata_d = i_extData;
          we_d    = i_extWe;
          state_d = S_SETUP;
        end else if (!i_extReq) begin
          cnt_d   = 8'd0;
          state_d = S_CPU;
        end
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        ack_d = 1'b1;
        if (!we_q) rdata_d = i_ramData;
        if (cnt_q + 8'd1 == BMAX) begin
          cnt_d   = 8'd0;
          state_d = S_COOL;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      S_COOL: begin
        cnt_d = 8'd0;
        if (!i_instrFinishedN) state_d = S_CPU;
      end
      default: state_d = S_CPU;
    endcase
    own_d = (state_d == S_IDLE) || (state_d == S_SETUP) || (state_d == S_STROBE);
  end

  always_ff @(posedge i_nclk) begin
    if (i_reset) begin
      state_q <= S_CPU;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 8'd0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      own_q   <= own_d;
    end
  end

  // RAM pin mux: CPU passes straight through unless the external side owns the RAM.
  always_comb begin
    o_ramAddr = i_cpuAddr;
    o_ramData = i_cpuData;
    o_ramNWE  = i_cpuRamNWE;
    o_ramNOE  = i_cpuRamNOE;
    case (state_q)
      S_IDLE: begin
        o_ramAddr = addr_q;
        o_ramData = wdata_q;
        o_ramNWE  = 1'b1;
        o_ramNOE  = 1'b1;
      end
      S_SETUP: begin
        o_ramAddr = addr_q;
        o_ramData = wdata_q;
        o_ramNWE  = 1'b1;
        o_ramNOE  = we_q;
      end
      S_STROBE: begin
        o_ramAddr = addr_q;
        o_ramData = wdata_q;
        o_ramNWE  = !we_q;
        o_ramNOE  = we_q;
      end
      default: ;
    endcase
  end

  assign o_cpuData = i_ramData;
  assign o_halt    = own_q;
  assign o_extGnt  = own_q;
  assign o_extAck  = ack_q;
  assign o_extData = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural RAM and access model.
module tb_mem_arbiter;
  localparam int AW   = 16;
  localparam int BMAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          finN;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          cpu_nwe, cpu_noe;
  logic [7:0]    cpu_rd;
  logic          halt;
  logic          req, we, stb;
  logic [AW-1:0] ext_addr;
  logic [7:0]    ext_wd;
  logic          gnt, ack;
  logic [7:0]    ext_rd;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wd, ram_rd;
  logic          ram_nwe, ram_noe;

  mem_arbiter #(.ADDR_W(AW), .BURST_MAX(BMAX)) dut (
    .i_nclk(clk), .i_reset(rst), .i_instrFinishedN(finN),
    .i_cpuAddr(cpu_addr), .i_cpuData(cpu_data), .i_cpuRamNWE(cpu_nwe), .i_cpuRamNOE(cpu_noe),
    .o_cpuData(cpu_rd), .o_halt(halt),
    .i_extReq(req), .i_extWe(we), .i_extStb(stb), .i_extAddr(ext_addr), .i_extData(ext_wd),
    .o_extGnt(gnt), .o_extAck(ack), .o_extData(ext_rd),
    .o_ramAddr(ram_addr), .o_ramData(ram_wd), .i_ramData(ram_rd),
    .o_ramNWE(ram_nwe), .o_ramNOE(ram_noe)
  );

  always #5 clk = ~clk;

  // Physical RAM on the pins
  logic [7:0] ram [0:65535];
  assign ram_rd = ram[ram_addr];
  always @(posedge clk) if (!ram_nwe) ram[ram_addr] <= ram_wd;

  // Reference model: contents seen by the external side and the held read value
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd;
  logic [7:0] exp_q [$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_ack: got ack with data %0h, expected no ack", ext_rd);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("ack_data", {24'd0, ext_rd}, {24'd0, e});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_mirror(input string nm);
    chk({nm, "_addr"}, {16'd0, ram_addr}, {16'd0, cpu_addr});
    chk({nm, "_wd"},   {24'd0, ram_wd},   {24'd0, cpu_data});
    chk({nm, "_nwe"},  {31'd0, ram_nwe},  {31'd0, cpu_nwe});
    chk({nm, "_noe"},  {31'd0, ram_noe},  {31'd0, cpu_noe});
    chk({nm, "_cpurd"}, {24'd0, cpu_rd},  {24'd0, ram_rd});
  endtask

  task automatic rand_cpu;
    cpu_addr = AW'($urandom_range(0, 32767)) | 16'h8000;
    cpu_data = 8'($urandom);
    cpu_noe  = 1'($urandom);
  endtask

  // Raise req, wait `extra` non-boundary cycles, then present one boundary.
  task automatic grant(input int extra);
    req = 1'b1;
    tick;
    chk("wait_halt", {31'd0, halt}, 32'd0);
    repeat (extra) begin
      rand_cpu;
      tick;
      chk("wait_halt", {31'd0, halt}, 32'd0);
      chk("wait_gnt", {31'd0, gnt}, 32'd0);
    end
    finN = 1'b0;
    tick;
    finN = 1'b1;
    chk("gnt_halt", {31'd0, halt}, 32'd1);
    chk("gnt_gnt", {31'd0, gnt}, 32'd1);
    cpu_noe = 1'b0;
    #1;
    chk("idle_noe_blocked", {31'd0, ram_noe}, 32'd1);
    chk("idle_nwe", {31'd0, ram_nwe}, 32'd1);
  endtask

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  // One external access from IDLE; optionally drops req in the strobe cycle.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [7:0] d, input logic drop);
    stb = 1'b1; we = w; ext_addr = a; ext_wd = d;
    if (drop) req = 1'b0;
    if (w) begin
      ref_mem[int'(a)] = d;
      exp_q.push_back(last_rd);
    end else begin
      last_rd = ref_rd(a);
      exp_q.push_back(last_rd);
    end
    tick;
    stb = 1'b0; ext_addr = 16'hFFFF; ext_wd = 8'hEE;
    chk("setup_addr", {16'd0, ram_addr}, {16'd0, a});
    chk("setup_nwe", {31'd0, ram_nwe}, 32'd1);
    chk("setup_noe", {31'd0, ram_noe}, {31'd0, w});
    if (w) chk("setup_wd", {24'd0, ram_wd}, {24'd0, d});
    tick;
    chk("strobe_nwe", {31'd0, ram_nwe}, {31'd0, !w});
    chk("strobe_noe", {31'd0, ram_noe}, {31'd0, w});
    chk("strobe_ack", {31'd0, ack}, 32'd0);
    tick;
    chk("ack_latency", {31'd0, ack}, 32'd1);
  endtask

  // From COOL: hold off for `n` cycles, then let one boundary through.
  task automatic cool_exit(input int n, input logic keep_req);
    chk("cool_halt", {31'd0, halt}, 32'd0);
    chk("cool_gnt", {31'd0, gnt}, 32'd0);
    repeat (n) begin
      tick;
      chk("cool_gnt_hold", {31'd0, gnt}, 32'd0);
      chk_mirror("cool_mirror");
    end
    req = keep_req;
    finN = 1'b0;
    tick;
    finN = 1'b1;
    chk("cool_exit_gnt", {31'd0, gnt}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    last_rd = 8'h00;
    finN = 1'b1; req = 1'b0; we = 1'b0; stb = 1'b0;
    ext_addr = '0; ext_wd = '0;
    cpu_addr = 16'h8000; cpu_data = 8'h00; cpu_nwe = 1'b1; cpu_noe = 1'b1;
    rst = 1'b1;

    // Reset with junk on every input
    @(negedge clk);
    rand_cpu;
    cpu_nwe = 1'($urandom); finN = 1'($urandom); req = 1'b1; stb = 1'b1;
    we = 1'($urandom); ext_addr = 16'h00AA; ext_wd = 8'($urandom);
    tick; tick;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", {24'd0, ext_rd}, 32'd0);
    chk_mirror("rst_mirror");
    cpu_nwe = 1'b1; finN = 1'b1; req = 1'b0; stb = 1'b0;
    rst = 1'b0;
    tick;

    // Boundary grant after 5 non-boundary cycles; write then read back
    grant(5);
    access(1'b1, 16'h1234, 8'h5A, 1'b0);
    access(1'b0, 16'h1234, 8'h00, 1'b0);
    chk("wr_rd_data", {24'd0, ext_rd}, 32'h5A);
    cool_exit(2, 1'b0);

    // Burst limit: third strobe in COOL ignored, served after re-grant
    grant(1);
    access(1'b1, 16'h0010, 8'hC3, 1'b0);
    access(1'b1, 16'h0011, 8'h3C, 1'b0);
    stb = 1'b1; we = 1'b0; ext_addr = 16'h0010;
    tick;
    stb = 1'b0;
    chk_mirror("cool_stb_ignored");
    cool_exit(3, 1'b1);
    tick;
    chk("regrant_wait", {31'd0, gnt}, 32'd0);
    finN = 1'b0;
    tick;
    finN = 1'b1;
    chk("regrant_gnt", {31'd0, gnt}, 32'd1);
    access(1'b0, 16'h0010, 8'h00, 1'b0);

    // Release by dropping req in IDLE
    req = 1'b0;
    tick;
    chk("rel_halt", {31'd0, halt}, 32'd0);
    chk("rel_gnt", {31'd0, gnt}, 32'd0);
    chk_mirror("rel_mirror");

    // Strobe and req drop in the same cycle: access still completes
    grant(0);
    access(1'b0, 16'h0011, 8'h00, 1'b1);
    tick;
    chk("drop_gnt", {31'd0, gnt}, 32'd0);
    chk_mirror("drop_mirror");

    // Reset while a write is in STROBE
    grant(2);
    cpu_noe = 1'b1;
    stb = 1'b1; we = 1'b1; ext_addr = 16'h0042; ext_wd = 8'h99;
    ref_mem[32'h42] = 8'h99;
    tick;
    stb = 1'b0;
    tick;
    rst = 1'b1; req = 1'b0; last_rd = 8'h00;
    tick;
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_nwe", {31'd0, ram_nwe}, 32'd1);
    chk("rst_mid_noe", {31'd0, ram_noe}, 32'd1);
    chk("rst_mid_gnt", {31'd0, gnt}, 32'd0);
    rst = 1'b0;
    tick;
    chk("rst_mid_ack2", {31'd0, ack}, 32'd0);
    chk_mirror("rst_mid_mirror");

    // Randomized grants with random access mixes
    for (int it = 0; it < 60; it++) begin
      int k;
      grant($urandom_range(0, 4));
      k = $urandom_range(0, BMAX);
      for (int j = 0; j < k; j++)
        access(1'($urandom), AW'($urandom_range(0, 63)), 8'($urandom), 1'b0);
      if (k == BMAX) begin
        cool_exit($urandom_range(0, 3), 1'b0);
      end else begin
        req = 1'b0;
        tick;
        chk("rnd_rel_gnt", {31'd0, gnt}, 32'd0);
        chk_mirror("rnd_rel_mirror");
      end
      repeat ($urandom_range(0, 3)) begin
        rand_cpu;
        tick;
        chk("rnd_cpu_halt", {31'd0, halt}, 32'd0);
      end
    end

    repeat (4) tick;
    chk("outstanding_acks", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data/instruction RAM between the CPU memory path and one external requester (debug/program loader). Ownership changes only at CPU instruction boundaries: the block waits for the control unit's instruction-finished strobe, then freezes the sequencer through its halt input and serves external accesses. Burst length is bounded so the CPU is never starved. It sits between the memory block's RAM strobes and the physical RAM pins.

## Interface
- ADDR_W, 16, RAM address width
- BURST_MAX, 8, max external accesses per grant (1..255)
- i_nclk  in  1  system clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_instrFinishedN  in  1  low in the last step of a CPU instruction
- i_cpuAddr  in  ADDR_W  CPU RAM address
- i_cpuData  in  8  CPU write data
- i_cpuRamNWE / i_cpuRamNOE  in  1 each  CPU RAM strobes, active low
- o_cpuData  out  8  RAM read data to CPU, always i_ramData
- o_halt  out  1  to control unit halt input; high freezes the step counter
- i_extReq  in  1  external requester wants the RAM, level
- i_extWe  in  1  1 = write, 0 = read; sampled with i_extStb
- i_extStb  in  1  one-cycle access strobe, honoured only when o_extGnt=1 and in IDLE
- i_extAddr  in  ADDR_W  external address, sampled with i_extStb
- i_extData  in  8  external write data, sampled with i_extStb
- o_extGnt  out  1  external side owns the RAM
- o_extAck  out  1  one-cycle pulse: access complete
- o_extData  out  8  read data, valid with o_extAck, held until next ack
- o_ramAddr  out  ADDR_W, o_ramData out 8, i_ramData in 8, o_ramNWE / o_ramNOE out 1 each  RAM pins

## Operation
- States: CPU, WAIT, IDLE, SETUP, STROBE, COOL. Reset: state CPU, o_halt=0, o_extGnt=0, o_extAck=0, o_extData=0x00, burst counter=0, ext address/data registers 0.
- CPU: RAM pins combinationally follow CPU inputs. i_extReq=1 -> WAIT.
- WAIT: RAM still follows CPU, o_halt=0. Sampled i_instrFinishedN=0 -> IDLE (o_halt and o_extGnt go high on that edge, so the next instruction is frozen at step 0). i_extReq dropped -> CPU.
- IDLE: o_halt=1, o_extGnt=1, o_ramNWE=o_ramNOE=1. i_extStb=1 -> latch addr/data/we, SETUP. Else i_extReq=0 -> CPU (halt and grant drop same edge). Stb takes priority over a same-cycle req drop.
- SETUP: drive latched address/data; read: o_ramNOE=0; write: strobes high (address setup) -> STROBE.
- STROBE: read: o_ramNOE=0, i_ramData captured into o_extData at end of cycle; write: o_ramNWE=0. Burst counter +1; o_extAck pulses next cycle. If counter reaches BURST_MAX -> COOL, else -> IDLE.
- COOL: o_halt=0, o_extGnt=0, counter cleared, RAM follows CPU. Leaves only after sampled i_instrFinishedN=0 -> CPU (then re-arbitrates normally). Guarantees at least one full CPU instruction between bursts.
- CPU strobes are ignored (not forwarded) in IDLE/SETUP/STROBE; they are inert anyway because the CPU is halted.
- Counter is 8 bit, saturates never (cleared on COOL/CPU entry); BURST_MAX=1 gives single-access grants.

## Timing
- Request to grant: 1 cycle after the first sampled i_instrFinishedN=0 at or after i_extReq rise (min 2 cycles from req).
- Access latency: stb at edge N -> SETUP N+1 -> STROBE N+2 -> o_extAck high during N+3; next stb accepted in N+3 (IDLE) or later. Throughput 1 access / 3 cycles.
- o_extAck, o_extData, o_halt, o_extGnt are registered; RAM pin mux is combinational from state.
- Reset mid-access (SETUP/STROBE): next cycle strobes high, halt/grant 0, no ack issued, state CPU.
- i_reset dominates all other inputs.

## Test plan
- Reset: drive junk on all inputs, assert i_reset 2 cycles -> o_halt=0, o_extGnt=0, o_extAck=0, o_extData=0x00, RAM pins mirror CPU inputs.
- Boundary grant: raise i_extReq while i_instrFinishedN=1 for 5 cycles -> o_halt stays 0; pulse i_instrFinishedN=0 -> o_halt=1 and o_extGnt=1 exactly one cycle later.
- Write then read: grant, stb write 0x5A to 0x1234, then read 0x1234 with RAM model -> o_ramNWE low only in STROBE, ack 3 cycles after each stb, o_extData=0x5A.
- Burst limit BURST_MAX=2: hold req, issue 3 stbs -> 2 acks, then o_halt=0, grant 0 until i_instrFinishedN=0 sampled, re-grant at next boundary, 3rd stb served.
- Release: drop i_extReq in IDLE -> next cycle o_halt=0, o_extGnt=0, RAM follows CPU; same-cycle stb+req drop -> access completes with ack first.
- Reset in STROBE of a write -> no ack, strobes high next cycle, state CPU.
